// File: rtl/csr_req_arbiter_pkg.sv
// Shared types and sizing helpers for the CSR request arbiter.
// The tag entry records which requester owns an in-flight access and whether it was a write.
package csr_req_arbiter_pkg;

    localparam int DEF_NUM_REQS    = 4;
    localparam int DEF_REQ_DATAW   = 128;
    localparam int DEF_RSP_DATAW   = 160;
    localparam int DEF_MAX_PENDING = 4;

    // Wide enough for any practical requester count; narrower indices are zero-extended.
    localparam int TAG_IDX_W = 8;

    localparam int PEND_W = $clog2(DEF_MAX_PENDING) + 1;

    typedef struct packed {
        logic                 write;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pend_width(input int max_pending);
        return $clog2(max_pending) + 1;
    endfunction

endpackage

// File: rtl/csr_req_arbiter_if.sv
// Bundle of requester, CSR-unit and response-routing signals around the arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface csr_req_arbiter_if import csr_req_arbiter_pkg::*; #(
    parameter int NUM_REQS    = DEF_NUM_REQS,
    parameter int REQ_DATAW   = DEF_REQ_DATAW,
    parameter int RSP_DATAW   = DEF_RSP_DATAW,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) ();

    localparam int PW = pend_width(MAX_PENDING);

    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS-1:0]           req_is_write;
    logic [NUM_REQS*REQ_DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]           req_ready;
    logic                          access_pending;
    logic                          out_valid;
    logic [REQ_DATAW-1:0]          out_data;
    logic                          out_ready;
    logic                          rsp_in_valid;
    logic [RSP_DATAW-1:0]          rsp_in_data;
    logic                          rsp_in_ready;
    logic [NUM_REQS-1:0]           rsp_valid;
    logic [RSP_DATAW-1:0]          rsp_data;
    logic [NUM_REQS-1:0]           rsp_ready;
    logic [PW-1:0]                 pending_count;
    logic                          busy;

    modport slave (
        input  req_valid, req_is_write, req_data, access_pending, out_ready,
               rsp_in_valid, rsp_in_data, rsp_ready,
        output req_ready, out_valid, out_data, rsp_in_ready, rsp_valid, rsp_data,
               pending_count, busy
    );

    modport master (
        output req_valid, req_is_write, req_data, access_pending, out_ready,
               rsp_in_valid, rsp_in_data, rsp_ready,
        input  req_ready, out_valid, out_data, rsp_in_ready, rsp_valid, rsp_data,
               pending_count, busy
    );

endinterface

// File: rtl/csr_req_arbiter_rr_picker.sv
// Combinational round-robin scan: first index that is both valid and eligible,
// starting at rr_ptr and wrapping modulo NUM_REQS.
module csr_rr_picker import csr_req_arbiter_pkg::*; #(
    parameter int NUM_REQS = DEF_NUM_REQS,
    parameter int IDX_W    = idx_width(DEF_NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [NUM_REQS-1:0] eligible,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                found
);

    logic [IDX_W-1:0]    pos [NUM_REQS];
    logic [NUM_REQS-1:0] rot;

    // rot[k] describes the requester k places after rr_ptr.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rot
        logic [IDX_W:0] raw;
        assign raw     = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
        assign pos[gi] = (raw >= (IDX_W+1)'(NUM_REQS)) ?
                         IDX_W'(raw - (IDX_W+1)'(NUM_REQS)) : raw[IDX_W-1:0];
        assign rot[gi] = valid[pos[gi]] & eligible[pos[gi]];
    end

    // Scanning downward lets the smallest offset overwrite any later match.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                winner = pos[i];
            end
        end
    end

endmodule

// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter sharing one CSR unit among NUM_REQS requesters, with an in-order
// tag FIFO for response routing, a write fence and an access_pending stall.
module csr_req_arbiter import csr_req_arbiter_pkg::*; #(
    parameter int NUM_REQS    = DEF_NUM_REQS,
    parameter int REQ_DATAW   = DEF_REQ_DATAW,
    parameter int RSP_DATAW   = DEF_RSP_DATAW,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) (
    input  logic              clk,
    input  logic              reset,
    csr_req_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQS);
    localparam int PW    = pend_width(MAX_PENDING);
    localparam int PTR_W = $clog2(MAX_PENDING);

    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic                 fence_reg, fence_next;
    logic [PW-1:0]        count_reg, count_next;
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    tag_t                 tag_mem [MAX_PENDING];

    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic [NUM_REQS-1:0]  eligible;
    logic [NUM_REQS-1:0]  rsp_sel;
    logic [REQ_DATAW-1:0] req_word [NUM_REQS];
    logic                 can_issue, out_valid, grant, pop, fifo_empty;
    tag_t                 head;

    assign fifo_empty = (count_reg == '0);
    assign head       = tag_mem[rd_ptr_reg];

    // A write may only issue into an empty pipe so no later read can overtake it.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
        assign eligible[gi]      = !bus.req_is_write[gi] || fifo_empty;
        assign req_word[gi]      = bus.req_data[gi*REQ_DATAW +: REQ_DATAW];
        assign bus.req_ready[gi] = out_valid && bus.out_ready && (winner == IDX_W'(gi));
        assign rsp_sel[gi]       = (head.idx == TAG_IDX_W'(gi));
        assign bus.rsp_valid[gi] = !reset && bus.rsp_in_valid && !fifo_empty && rsp_sel[gi];
    end

    csr_rr_picker #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .valid    (bus.req_valid),
        .eligible (eligible),
        .rr_ptr   (rr_ptr_reg),
        .winner   (winner),
        .found    (found)
    );

    assign can_issue = !reset && !bus.access_pending && !fence_reg &&
                       (count_reg < PW'(MAX_PENDING));
    assign out_valid = can_issue && found;
    assign grant     = out_valid && bus.out_ready;

    assign bus.out_valid     = out_valid;
    assign bus.out_data      = req_word[winner];
    assign bus.rsp_in_ready  = !reset && !fifo_empty && |(bus.rsp_ready & rsp_sel);
    assign bus.rsp_data      = bus.rsp_in_data;
    assign bus.pending_count = count_reg;
    assign bus.busy          = !fifo_empty || fence_reg;

    assign pop = bus.rsp_in_valid && bus.rsp_in_ready;

    // A grant never coincides with a write pop: the fence blocks grants while a write is out.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        fence_next  = fence_reg;
        count_next  = count_reg;
        if (grant) begin
            rr_ptr_next = (winner == IDX_W'(NUM_REQS - 1)) ? '0 : winner + 1'b1;
        end
        if (grant && bus.req_is_write[winner]) begin
            fence_next = 1'b1;
        end else if (pop && head.write) begin
            fence_next = 1'b0;
        end
        case ({grant, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
            fence_reg  <= 1'b0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            fence_reg  <= fence_next;
            count_reg  <= count_next;
            if (grant) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Tag storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr_reg] <= '{write: bus.req_is_write[winner],
                                     idx:   TAG_IDX_W'(winner)};
        end
    end

    // A response with nothing in flight indicates a protocol error in the CSR unit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.rsp_in_valid && fifo_empty));
        end
    end

endmodule

// File: tb/tb_csr_req_arbiter.sv
// Bench for csr_req_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_csr_req_arbiter;

    localparam int N   = 4;
    localparam int RQW = 128;
    localparam int RSW = 160;
    localparam int MP  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_req_arbiter_if #(.NUM_REQS(N), .REQ_DATAW(RQW), .RSP_DATAW(RSW), .MAX_PENDING(MP)) bus ();

    csr_req_arbiter #(.NUM_REQS(N), .REQ_DATAW(RQW), .RSP_DATAW(RSW), .MAX_PENDING(MP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner queue, write flags, pointer and fence.
    int m_ptr;
    bit m_fence;
    int m_qi[$];
    bit m_qw[$];

    bit           e_ov, e_rir, e_busy;
    logic [N-1:0] e_rr, e_rspv;
    int           e_cnt, e_win;

    logic [RQW-1:0] drv_data [N];

    logic         obs_ov, obs_rir;
    logic [N-1:0] obs_rr, obs_rspv;
    int           obs_cnt;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] wr;
        logic         ordy;
        logic         rv;
        logic [N-1:0] rrdy;
        logic         ap;
        logic         x_ov;
        logic [N-1:0] x_rr;
        logic [N-1:0] x_rspv;
        int           x_cnt;
        logic         x_busy;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] valid, input logic [N-1:0] wr, input logic ordy,
                         input logic rv, input logic [N-1:0] rrdy, input logic ap);
        bus.req_valid      = valid;
        bus.req_is_write   = wr;
        bus.out_ready      = ordy;
        bus.rsp_in_valid   = rv;
        bus.rsp_ready      = rrdy;
        bus.access_pending = ap;
        for (int i = 0; i < N; i++) begin
            drv_data[i] = {$urandom, $urandom, $urandom, $urandom};
            bus.req_data[i*RQW +: RQW] = drv_data[i];
        end
        bus.rsp_in_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic clear_model();
        m_ptr   = 0;
        m_fence = 1'b0;
        m_qi.delete();
        m_qw.delete();
    endtask

    task automatic model_eval();
        int cnt;
        bit can;
        cnt   = m_qi.size();
        e_win = -1;
        can   = !bus.access_pending && !m_fence && (cnt < MP);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (e_win < 0 && bus.req_valid[i] && (!bus.req_is_write[i] || cnt == 0))
                e_win = i;
        end
        e_ov   = can && (e_win >= 0);
        e_rr   = '0;
        e_rspv = '0;
        e_rir  = 1'b0;
        if (e_ov && bus.out_ready) e_rr[e_win] = 1'b1;
        if (cnt > 0) begin
            e_rir = bus.rsp_ready[m_qi[0]];
            if (bus.rsp_in_valid) e_rspv[m_qi[0]] = 1'b1;
        end
        e_cnt  = cnt;
        e_busy = (cnt != 0) || m_fence;
    endtask

    task automatic model_update();
        if (e_rir && bus.rsp_in_valid) begin
            int r;
            bit w;
            r = m_qi.pop_front();
            w = m_qw.pop_front();
            if (w) m_fence = 1'b0;
            $display("t=%0t response to req %0d write=%0b", $time, r, w);
        end
        if (e_ov && bus.out_ready) begin
            m_qi.push_back(e_win);
            m_qw.push_back(bus.req_is_write[e_win]);
            if (bus.req_is_write[e_win]) m_fence = 1'b1;
            m_ptr = (e_win + 1) % N;
            $display("t=%0t grant req %0d write=%0b", $time, e_win, bus.req_is_write[e_win]);
        end
    endtask

    task automatic observe();
        obs_ov   = bus.out_valid;
        obs_rr   = bus.req_ready;
        obs_rspv = bus.rsp_valid;
        obs_rir  = bus.rsp_in_ready;
        obs_cnt  = int'(bus.pending_count);
    endtask

    // One clock: compare against the model at the falling edge, then advance.
    task automatic tick();
        @(negedge clk);
        observe();
        model_eval();
        chk("out_valid", 160'(bus.out_valid), 160'(e_ov));
        if (e_ov) chk("out_data", 160'(bus.out_data), 160'(drv_data[e_win]));
        chk("req_ready", 160'(bus.req_ready), 160'(e_rr));
        chk("rsp_valid", 160'(bus.rsp_valid), 160'(e_rspv));
        chk("rsp_in_ready", 160'(bus.rsp_in_ready), 160'(e_rir));
        chk("rsp_data", 160'(bus.rsp_data), 160'(bus.rsp_in_data));
        chk("pending_count", 160'(bus.pending_count), 160'(e_cnt));
        chk("busy", 160'(bus.busy), 160'(e_busy));
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
        @(negedge clk);
        chk("reset_out_valid", 160'(bus.out_valid), 160'(0));
        chk("reset_req_ready", 160'(bus.req_ready), 160'(0));
        chk("reset_rsp_valid", 160'(bus.rsp_valid), 160'(0));
        chk("reset_rsp_in_ready", 160'(bus.rsp_in_ready), 160'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    initial begin
        int head, cnt0, ptr0;
        // valid   wr      ordy  rv    rrdy    ap  | ov   rr      rspv    cnt busy
        tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0000, 0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0001, 1, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0010, 1, 1'b1};
        tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, 4'b0100, 1, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'b1000, 1, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0001, 1, 1'b1};
        tbl[6]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0000, 0, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0010, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0000, 1, 1'b1};
        tbl[8]  = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 2, 1'b1};
        tbl[9]  = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0100, 2, 1'b1};
        tbl[10] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0001, 1, 1'b1};
        tbl[11] = '{4'b0111, 4'b0010, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0000, 0, 1'b0};
        tbl[12] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 1, 1'b1};
        tbl[13] = '{4'b0101, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0010, 1, 1'b1};
        tbl[14] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0000, 0, 1'b0};

        do_reset();

        // Round-robin read stream followed by the write-fence scenario.
        for (int v = 0; v < 15; v++) begin
            drive(tbl[v].valid, tbl[v].wr, tbl[v].ordy, tbl[v].rv, tbl[v].rrdy, tbl[v].ap);
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", v), 160'(bus.out_valid), 160'(tbl[v].x_ov));
            chk($sformatf("vec%0d_req_ready", v), 160'(bus.req_ready), 160'(tbl[v].x_rr));
            chk($sformatf("vec%0d_rsp_valid", v), 160'(bus.rsp_valid), 160'(tbl[v].x_rspv));
            chk($sformatf("vec%0d_pending_count", v), 160'(bus.pending_count), 160'(tbl[v].x_cnt));
            chk($sformatf("vec%0d_busy", v), 160'(bus.busy), 160'(tbl[v].x_busy));
            for (int i = 0; i < N; i++)
                if (tbl[v].x_rr[i]) chk($sformatf("vec%0d_out_data", v), 160'(bus.out_data), 160'(drv_data[i]));
            model_eval();
            model_update();
            @(posedge clk);
            #1;
        end

        // access_pending held for five cycles blocks every grant.
        ptr0 = m_ptr;
        for (int c = 0; c < 5; c++) begin
            drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1);
            tick();
            chk("apend_blocks", 160'(obs_ov), 160'(0));
        end
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
        tick();
        chk("apend_release_grant", 160'(obs_rr), 160'(1 << ptr0));

        // Fill to MAX_PENDING, then pop and grant together.
        do_reset();
        for (int c = 0; c < MP; c++) begin
            drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
            tick();
        end
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
        tick();
        chk("full_out_valid", 160'(obs_ov), 160'(0));
        chk("full_count", 160'(obs_cnt), 160'(MP));
        drive(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0);
        tick();
        drive(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0);
        tick();
        chk("swap_grant", 160'(obs_ov), 160'(1));
        chk("swap_pop", 160'(obs_rir), 160'(1));
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
        tick();
        chk("swap_count_held", 160'(obs_cnt), 160'(MP - 1));
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
        tick();
        chk("refill_count", 160'(obs_cnt), 160'(MP));

        // Head requester refuses its response for three cycles.
        head = m_qi[0];
        cnt0 = m_qi.size();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 4'b0000, 1'b1, 1'b1, ~(4'b0001 << head), 1'b0);
            tick();
            chk("stall_rsp_in_ready", 160'(obs_rir), 160'(0));
            chk("stall_count", 160'(obs_cnt), 160'(cnt0));
        end
        while (m_qi.size() > 0) begin
            head = m_qi[0];
            drive(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0);
            tick();
            chk("drain_rsp_valid", 160'(obs_rspv), 160'(1 << head));
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 300; c++) begin
            logic rv;
            rv = (m_qi.size() > 0) && ($urandom_range(0, 9) < 6);
            drive(4'($urandom), 4'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0),
                  rv, 4'($urandom | $urandom), ($urandom_range(0, 9) == 0));
            tick();
        end

        // Reset with three reads in flight discards every tag.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
            tick();
        end
        do_reset();
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0);
        tick();
        chk("post_reset_count", 160'(obs_cnt), 160'(0));
        chk("post_reset_rsp_valid", 160'(obs_rspv), 160'(0));
        chk("post_reset_ptr", 160'(obs_rr), 160'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
